// File: rtl/store_queue_align.sv
// ----------------------------------------------------------------------------
// store_queue_align
//   Buffered store aligner between the MEM stage and the data-memory/bus bridge.
//   Each incoming store (sw/sh/sb/swl/swr) is turned into a word address, a
//   32-bit lane-aligned data word and a 4-bit byte enable. Aligned stores are
//   queued in a DEPTH-entry FIFO. A store to the same word as the youngest
//   entry is merged into that entry, but never into the entry on the memory
//   bus. The FIFO drains over a valid/ready handshake. A combinational lookup
//   tells the load path whether any pending store overlaps a load.
//
// Ports
//   clk_i          clock, rising edge
//   reset_ni       asynchronous active-low reset
//   in_valid_i     store request present
//   in_ready_o     request can be accepted this cycle
//   in_ctrl_i      000 none, 001 sw, 010 sh, 011 sb, 100 swl, 101 swr, 11x none
//   in_addr_i      byte address of the store
//   in_data_i      unaligned store data (rt)
//   mem_valid_o    head entry presented to memory
//   mem_ready_i    memory accepts the head entry
//   mem_addr_o     head word address, bits [1:0] = 00
//   mem_data_o     head lane data
//   mem_byteen_o   head byte enables
//   lu_addr_i      load address to check
//   lu_byteen_i    bytes the load reads
//   lu_hit_o       a pending entry overlaps the load
//   align_err_o    one-cycle pulse after a misaligned sw/sh was dropped
//   count_o        number of valid entries
//   empty_o        count_o == 0
//   full_o         count_o == DEPTH
// ----------------------------------------------------------------------------

// One queue slot: holds a word address, lane data and byte enables, and
// answers the load-hazard lookup for itself.
module store_queue_align_entry #(
   parameter int WAW = 30
) (
   input  logic           clk_i,
   input  logic           reset_ni,
   input  logic           alloc_i,
   input  logic           merge_i,
   input  logic           pop_i,
   input  logic [WAW-1:0] waddr_i,
   input  logic [31:0]    data_i,
   input  logic [3:0]     en_i,
   input  logic [WAW-1:0] lu_waddr_i,
   input  logic [3:0]     lu_byteen_i,
   output logic           vld_o,
   output logic [WAW-1:0] waddr_o,
   output logic [31:0]    data_o,
   output logic [3:0]     en_o,
   output logic           lu_hit_o
);
   logic           vld_q;
   logic [WAW-1:0] waddr_q;
   logic [31:0]    data_q;
   logic [3:0]     en_q;
   logic [31:0]    mrg_data;

   // Bytes enabled by the new store replace the held bytes; others are kept.
   always_comb begin
      mrg_data = data_q;
      for (int b = 0; b < 4; b++) begin
         if (en_i[b]) mrg_data[8*b +: 8] = data_i[8*b +: 8];
      end
   end

   // alloc/merge/pop never target this slot together: alloc needs a free
   // slot, and merge only hits the youngest slot, which is never the head.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         vld_q   <= 1'b0;
         waddr_q <= '0;
         data_q  <= '0;
         en_q    <= '0;
      end else if (alloc_i) begin
         vld_q   <= 1'b1;
         waddr_q <= waddr_i;
         data_q  <= data_i;
         en_q    <= en_i;
      end else if (merge_i) begin
         data_q  <= mrg_data;
         en_q    <= en_q | en_i;
      end else if (pop_i) begin
         vld_q   <= 1'b0;
      end
   end

   assign vld_o    = vld_q;
   assign waddr_o  = waddr_q;
   assign data_o   = data_q;
   assign en_o     = en_q;
   assign lu_hit_o = vld_q && (waddr_q == lu_waddr_i) && |(en_q & lu_byteen_i);
endmodule

module store_queue_align #(
   parameter int AW    = 32,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          reset_ni,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [2:0]    in_ctrl_i,
   input  logic [AW-1:0] in_addr_i,
   input  logic [31:0]   in_data_i,
   output logic          mem_valid_o,
   input  logic          mem_ready_i,
   output logic [AW-1:0] mem_addr_o,
   output logic [31:0]   mem_data_o,
   output logic [3:0]    mem_byteen_o,
   input  logic [AW-1:0] lu_addr_i,
   input  logic [3:0]    lu_byteen_i,
   output logic          lu_hit_o,
   output logic          align_err_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o,
   output logic          full_o
);
   localparam int WAW = AW - 2;
   localparam int PW  = $clog2(DEPTH);

   typedef struct packed {
      logic [WAW-1:0] waddr;
      logic [31:0]    data;
      logic [3:0]     en;
   } sq_req_t;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, yng_ptr;
   logic [CW-1:0] count_q, count_d;
   logic          align_err_q, align_err_d;

   sq_req_t       req;
   logic          is_store, misal;
   logic          accept, do_store, push, merge, pop, merge_hit;
   logic [1:0]    a;

   logic [DEPTH-1:0]          ent_vld, ent_lu_hit;
   logic [DEPTH-1:0][WAW-1:0] ent_waddr;
   logic [DEPTH-1:0][31:0]    ent_data;
   logic [DEPTH-1:0][3:0]     ent_en;

   // Load byte offset is irrelevant: overlap is judged by word and byte enable.
   logic lu_unused;
   assign lu_unused = ^lu_addr_i[1:0];

   // ---------------- alignment ----------------
   assign a = in_addr_i[1:0];

   always_comb begin
      req.waddr = in_addr_i[AW-1:2];
      req.data  = in_data_i;
      req.en    = 4'b0000;
      is_store  = 1'b0;
      misal     = 1'b0;
      case (in_ctrl_i)
         3'b001: begin                        // sw
            is_store = 1'b1;
            req.en   = 4'b1111;
            misal    = (a != 2'b00);
         end
         3'b010: begin                        // sh
            is_store = 1'b1;
            req.data = in_data_i << {a[1], 4'b0000};
            req.en   = 4'b0011 << {a[1], 1'b0};
            misal    = a[0];
         end
         3'b011: begin                        // sb
            is_store = 1'b1;
            req.data = in_data_i << {a, 3'b000};
            req.en   = 4'b0001 << a;
         end
         3'b100: begin                        // swl: shift by 3-a == ~a
            is_store = 1'b1;
            req.data = in_data_i >> {~a, 3'b000};
            req.en   = 4'b1111 >> ~a;
         end
         3'b101: begin                        // swr
            is_store = 1'b1;
            req.data = in_data_i << {a, 3'b000};
            req.en   = 4'b1111 << a;
         end
         default: ;                           // none / 11x
      endcase
   end

   // ---------------- queue control ----------------
   assign yng_ptr = wr_ptr_q - PW'(1);
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));

   // With a single entry the youngest is the head, which is on the bus and
   // must stay stable, so merging needs at least two entries.
   assign merge_hit = (count_q >= CW'(2)) && ent_vld[yng_ptr] &&
                      (ent_waddr[yng_ptr] == in_addr_i[AW-1:2]);

   // No bypass from mem_ready: a pop in the same cycle does not free a slot.
   assign in_ready_o = !full_o || merge_hit;
   assign accept     = in_valid_i && in_ready_o;
   assign do_store   = accept && is_store && !misal;
   assign push       = do_store && !merge_hit;
   assign merge      = do_store && merge_hit;
   assign pop        = mem_valid_o && mem_ready_i;

   always_comb begin
      wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d     = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
      align_err_d = accept && misal;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         align_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         align_err_q <= align_err_d;
      end
   end

   // ---------------- entries ----------------
   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      store_queue_align_entry #(.WAW(WAW)) u_ent (
         .clk_i       (clk_i),
         .reset_ni    (reset_ni),
         .alloc_i     (push  && (wr_ptr_q == PW'(i))),
         .merge_i     (merge && (yng_ptr  == PW'(i))),
         .pop_i       (pop   && (rd_ptr_q == PW'(i))),
         .waddr_i     (req.waddr),
         .data_i      (req.data),
         .en_i        (req.en),
         .lu_waddr_i  (lu_addr_i[AW-1:2]),
         .lu_byteen_i (lu_byteen_i),
         .vld_o       (ent_vld[i]),
         .waddr_o     (ent_waddr[i]),
         .data_o      (ent_data[i]),
         .en_o        (ent_en[i]),
         .lu_hit_o    (ent_lu_hit[i])
      );
   end

   // Head fields come straight from entry registers; the head slot is never
   // written while it is valid, so the beat holds until it is accepted.
   assign mem_valid_o  = !empty_o;
   assign mem_addr_o   = {ent_waddr[rd_ptr_q], 2'b00};
   assign mem_data_o   = ent_data[rd_ptr_q];
   assign mem_byteen_o = ent_en[rd_ptr_q];

   assign lu_hit_o    = |ent_lu_hit;
   assign align_err_o = align_err_q;
   assign count_o     = count_q;
endmodule

// File: tb/tb_store_queue_align.sv
module tb_store_queue_align;
   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   localparam logic [2:0] C_NONE = 3'b000, C_SW = 3'b001, C_SH = 3'b010,
                          C_SB = 3'b011, C_SWL = 3'b100, C_SWR = 3'b101;

   logic          clk_i = 1'b0;
   logic          reset_ni = 1'b0;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic [2:0]    in_ctrl_i = '0;
   logic [AW-1:0] in_addr_i = '0;
   logic [31:0]   in_data_i = '0;
   logic          mem_valid_o;
   logic          mem_ready_i = 1'b0;
   logic [AW-1:0] mem_addr_o;
   logic [31:0]   mem_data_o;
   logic [3:0]    mem_byteen_o;
   logic [AW-1:0] lu_addr_i = '0;
   logic [3:0]    lu_byteen_i = '0;
   logic          lu_hit_o;
   logic          align_err_o;
   logic [CW-1:0] count_o;
   logic          empty_o;
   logic          full_o;

   always #5 clk_i = ~clk_i;

   store_queue_align #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_ctrl_i(in_ctrl_i),
      .in_addr_i(in_addr_i), .in_data_i(in_data_i),
      .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_byteen_o(mem_byteen_o),
      .lu_addr_i(lu_addr_i), .lu_byteen_i(lu_byteen_i), .lu_hit_o(lu_hit_o),
      .align_err_o(align_err_o), .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  en;
   } beat_t;

   beat_t exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic beat_t bt(input logic [31:0] ad, input logic [31:0] d, input logic [3:0] e);
      beat_t b;
      b.addr = ad; b.data = d; b.en = e;
      return b;
   endfunction

   // Monitor: every presented beat must match the scoreboard head; pop it on handshake.
   always @(negedge clk_i) begin
      if (reset_ni && mem_valid_o) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat_unexpected actual=%0h/%0h/%0h", mem_addr_o, mem_data_o, mem_byteen_o);
         end else begin
            chk("mem_beat", {mem_addr_o, mem_data_o, mem_byteen_o}, exp_q[0]);
            if (mem_ready_i) exp_q.delete(0);
         end
      end
   end

   // Inputs change at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [2:0] c, input logic [31:0] ad, input logic [31:0] d);
      in_valid_i = 1'b1; in_ctrl_i = c; in_addr_i = ad; in_data_i = d;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      mem_ready_i = 1'b1;
      for (int n = 0; n < 40 && !done; n++) begin
         @(posedge clk_i); #1;
         if (empty_o) done = 1'b1;
      end
      mem_ready_i = 1'b0;
      chk("drain_empty", 68'(empty_o), 68'(1));
      chk("drain_scoreboard", 68'(exp_q.size()), 68'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset state ----
      #12;
      chk("rst_mem_valid", 68'(mem_valid_o), 68'(0));
      chk("rst_empty",     68'(empty_o),     68'(1));
      chk("rst_full",      68'(full_o),      68'(0));
      chk("rst_lu_hit",    68'(lu_hit_o),    68'(0));
      chk("rst_align_err", 68'(align_err_o), 68'(0));
      chk("rst_count",     68'(count_o),     68'(0));
      reset_ni = 1'b1;
      @(posedge clk_i); #1;

      // ---- sb alignment and one-cycle latency ----
      exp_q.push_back(bt(32'h1000, 32'hAB000000, 4'b1000));
      send(C_SB, 32'h1003, 32'h000000AB);
      chk("sb_latency_valid", 68'(mem_valid_o), 68'(1));
      chk("sb_count", 68'(count_o), 68'(1));
      drain();

      // ---- swl / swr to the same word; count==1 so no merge ----
      exp_q.push_back(bt(32'h2000, 32'h00001122, 4'b0011));
      send(C_SWL, 32'h2001, 32'h11223344);
      exp_q.push_back(bt(32'h2000, 32'h22334400, 4'b1110));
      send(C_SWR, 32'h2001, 32'h11223344);
      chk("swlr_no_merge_count", 68'(count_o), 68'(2));
      drain();

      // ---- merge into youngest ----
      exp_q.push_back(bt(32'h0010, 32'hDEADBEEF, 4'b1111));
      send(C_SW, 32'h10, 32'hDEADBEEF);
      send(C_SB, 32'h20, 32'h000000A1);
      send(C_SB, 32'h21, 32'h000000B2);
      send(C_SB, 32'h22, 32'h000000C3);
      chk("merge_count", 68'(count_o), 68'(2));
      exp_q.push_back(bt(32'h0020, 32'h00C3B2A1, 4'b0111));
      drain();

      // ---- fill to full ----
      for (int k = 0; k < 4; k++) begin
         if (k < 3) exp_q.push_back(bt(32'h100 + 32'(4*k), 32'(k+1), 4'b1111));
         send(C_SW, 32'h100 + 32'(4*k), 32'(k+1));
      end
      chk("full_flag",  68'(full_o),  68'(1));
      chk("full_count", 68'(count_o), 68'(4));
      in_valid_i = 1'b1; in_ctrl_i = C_SW; in_addr_i = 32'h110; in_data_i = 32'h5;
      #1;
      chk("full_refuse_ready", 68'(in_ready_o), 68'(0));
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      chk("full_refuse_count", 68'(count_o), 68'(4));
      // same-word sh into youngest while full
      in_valid_i = 1'b1; in_ctrl_i = C_SH; in_addr_i = 32'h10E; in_data_i = 32'h00005566;
      #1;
      chk("full_merge_ready", 68'(in_ready_o), 68'(1));
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      chk("full_merge_count", 68'(count_o), 68'(4));
      exp_q.push_back(bt(32'h10C, 32'h55660004, 4'b1111));
      // full with a pop in the same cycle: new word still refused
      in_valid_i = 1'b1; in_ctrl_i = C_SW; in_addr_i = 32'h110; in_data_i = 32'h5;
      mem_ready_i = 1'b1;
      #1;
      chk("full_pop_ready", 68'(in_ready_o), 68'(0));
      @(posedge clk_i); #1;
      in_valid_i = 1'b0; mem_ready_i = 1'b0;
      chk("full_pop_count", 68'(count_o), 68'(3));
      // hold a stalled beat for a few cycles before draining
      repeat (3) @(posedge clk_i);
      #1;
      drain();

      // ---- misaligned and none requests ----
      send(C_SW, 32'h3002, 32'h12345678);
      chk("sw_mis_err",   68'(align_err_o), 68'(1));
      chk("sw_mis_count", 68'(count_o),     68'(0));
      @(posedge clk_i); #1;
      chk("sw_mis_err_clear", 68'(align_err_o), 68'(0));
      send(C_SH, 32'h3001, 32'h12345678);
      chk("sh_mis_err",   68'(align_err_o), 68'(1));
      chk("sh_mis_count", 68'(count_o),     68'(0));
      send(C_NONE, 32'h3000, 32'h1);
      chk("none_err",   68'(align_err_o), 68'(0));
      chk("none_count", 68'(count_o),     68'(0));
      send(3'b110, 32'h3000, 32'h1);
      chk("ctrl6_count", 68'(count_o), 68'(0));

      // ---- load-hazard lookup ----
      exp_q.push_back(bt(32'h40, 32'h00990000, 4'b0100));
      send(C_SB, 32'h42, 32'h00000099);
      lu_addr_i = 32'h41; lu_byteen_i = 4'b0010; #1;
      chk("lu_miss_bytes", 68'(lu_hit_o), 68'(0));
      lu_byteen_i = 4'b0100; #1;
      chk("lu_hit", 68'(lu_hit_o), 68'(1));
      lu_addr_i = 32'h44; #1;
      chk("lu_miss_word", 68'(lu_hit_o), 68'(0));

      // ---- reset with a pending store ----
      reset_ni = 1'b0;
      #1;
      chk("midrst_valid", 68'(mem_valid_o), 68'(0));
      chk("midrst_empty", 68'(empty_o),     68'(1));
      chk("midrst_count", 68'(count_o),     68'(0));
      lu_addr_i = 32'h41; #1;
      chk("midrst_lu", 68'(lu_hit_o), 68'(0));
      exp_q.delete();
      @(negedge clk_i);
      reset_ni = 1'b1;
      @(posedge clk_i); #1;
      chk("post_rst_empty", 68'(empty_o), 68'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
